// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and helpers for the multi-channel timer
package timer_pkg;

  // Channel life cycle: idle until enabled, counting, or parked after a one-shot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Low bit index of channel i inside a packed N_CH*w bus.
  function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - shared divide-by-PRESC tick generator
module timer_prescaler #(
  parameter int unsigned PRESC = 1
) (
  input  logic clkSignal,
  input  logic RST_n,
  input  logic en,
  output logic tick
);

  // A one-bit counter is kept for PRESC=1; it simply never leaves zero.
  localparam int unsigned    PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]  LAST = PW'(PRESC - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Advance the phase only while enabled; a frozen enable holds the phase.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clkSignal) begin
    if (!RST_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N-channel periodic/one-shot timer sharing one prescaler
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 18,
  parameter int unsigned PRESC = 1
) (
  input  logic                    clkSignal,
  input  logic                    RST_n,
  input  logic                    EN,
  input  logic [N_CH-1:0]         chEn,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         oneShot,
  input  logic [N_CH*CNT_W-1:0]   maxCount,
  output logic [N_CH-1:0]         clkFinish,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH*CNT_W-1:0]   count,
  output logic                    anyFinish
);

  logic tick;

  timer_prescaler #(
    .PRESC (PRESC)
  ) u_prescaler (
    .clkSignal (clkSignal),
    .RST_n     (RST_n),
    .en        (EN),
    .tick      (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int unsigned LO = slice_lo(i, CNT_W);

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic               fin_q, fin_d;
    logic               chen_prev_q, chen_prev_d;
    logic [CNT_W-1:0]   max_slice;
    logic               at_terminal;

    assign max_slice   = maxCount[LO +: CNT_W];
    // reload==0 is a legal degenerate setting that must never reach terminal.
    assign at_terminal = (reload_q != '0) && (cnt_q == reload_q - CNT_W'(1));

    // Next-state logic: disable dominates, then restart, then tick-driven counting.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      fin_d       = 1'b0;
      chen_prev_d = chEn[i];

      if (!chEn[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!chen_prev_q || start[i]) begin
              state_d  = RUN;
              cnt_d    = '0;
              reload_d = max_slice;
            end
          end
          RUN: begin
            // A restart strobe beats a coincident terminal tick: no pulse.
            if (start[i]) begin
              cnt_d    = '0;
              reload_d = max_slice;
            end else if (tick) begin
              if (at_terminal) begin
                fin_d    = 1'b1;
                cnt_d    = '0;
                reload_d = max_slice;
                state_d  = (oneShot[i] == MODE_ONESHOT) ? DONE : RUN;
              end else if (reload_q != '0) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          DONE: begin
            if (start[i]) begin
              state_d  = RUN;
              cnt_d    = '0;
              reload_d = max_slice;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Channel registers with synchronous active-low reset.
    always_ff @(posedge clkSignal) begin
      if (!RST_n) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        reload_q    <= '0;
        fin_q       <= 1'b0;
        chen_prev_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        reload_q    <= reload_d;
        fin_q       <= fin_d;
        chen_prev_q <= chen_prev_d;
      end
    end

    assign clkFinish[i]          = fin_q;
    assign busy[i]               = (state_q == RUN);
    assign count[LO +: CNT_W]    = cnt_q;
  end

  assign anyFinish = |clkFinish;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer
module tb_multi_timer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 18;

  logic                  clk;
  logic                  rst_n;

  logic                  en, en4;
  logic [N_CH-1:0]       ch_en, ch_en4;
  logic [N_CH-1:0]       start, start4;
  logic [N_CH-1:0]       one_shot, one_shot4;
  logic [N_CH*CNT_W-1:0] max_count, max_count4;
  logic [N_CH-1:0]       clk_finish, clk_finish4;
  logic [N_CH-1:0]       busy, busy4;
  logic [N_CH*CNT_W-1:0] count, count4;
  logic                  any_finish, any_finish4;

  int n_checks = 0;
  int n_fail   = 0;

  multi_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC(1)) dut (
    .clkSignal (clk),
    .RST_n     (rst_n),
    .EN        (en),
    .chEn      (ch_en),
    .start     (start),
    .oneShot   (one_shot),
    .maxCount  (max_count),
    .clkFinish (clk_finish),
    .busy      (busy),
    .count     (count),
    .anyFinish (any_finish)
  );

  multi_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC(4)) dut4 (
    .clkSignal (clk),
    .RST_n     (rst_n),
    .EN        (en4),
    .chEn      (ch_en4),
    .start     (start4),
    .oneShot   (one_shot4),
    .maxCount  (max_count4),
    .clkFinish (clk_finish4),
    .busy      (busy4),
    .count     (count4),
    .anyFinish (any_finish4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with every input driven high
    rst_n      = 1'b0;
    en         = 1'b1;  en4        = 1'b1;
    ch_en      = '1;    ch_en4     = '1;
    start      = '1;    start4     = '1;
    one_shot   = '1;    one_shot4  = '1;
    max_count  = '1;    max_count4 = '1;
    step();
    step();
    check("rst_finish", 64'(clk_finish), 0);
    check("rst_busy",   64'(busy), 0);
    check("rst_count",  64'(|count), 0);
    check("rst_any",    64'(any_finish), 0);
    check("rst_busy4",  64'(busy4), 0);

    en        = 1'b1;  en4        = 1'b0;
    ch_en     = '0;    ch_en4     = '0;
    start     = '0;    start4     = '0;
    one_shot  = '0;    one_shot4  = '0;
    max_count = '0;    max_count4 = '0;
    rst_n     = 1'b1;
    step();

    // Periodic ch0, M=5: pulses at 5, 10, 15 clocks after enable
    max_count[0 +: CNT_W] = 18'd5;
    ch_en[0] = 1'b1;
    step();
    check("per_busy0_start", 64'(busy[0]), 1);
    check("per_cnt0_start",  64'(count[0 +: CNT_W]), 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("per_fin0_k%0d", k), 64'(clk_finish[0]), 64'(k % 5 == 0));
      check($sformatf("per_cnt0_k%0d", k), 64'(count[0 +: CNT_W]), 64'(k % 5));
      check($sformatf("per_busy0_k%0d", k), 64'(busy[0]), 1);
    end

    // chEn0 dropped mid-count: one IDLE clock, then restart from 0
    step();
    step();
    check("chen_cnt_before", 64'(count[0 +: CNT_W]), 2);
    ch_en[0] = 1'b0;
    step();
    check("chen_off_busy", 64'(busy[0]), 0);
    check("chen_off_cnt",  64'(count[0 +: CNT_W]), 0);
    ch_en[0] = 1'b1;
    step();
    check("chen_on_busy", 64'(busy[0]), 1);
    check("chen_on_cnt",  64'(count[0 +: CNT_W]), 0);
    step();
    step();
    check("chen_on_cnt2", 64'(count[0 +: CNT_W]), 2);
    ch_en[0] = 1'b0;
    step();

    // One-shot ch1, M=3, then restart by start strobe
    one_shot[1] = 1'b1;
    max_count[CNT_W +: CNT_W] = 18'd3;
    ch_en[1] = 1'b1;
    step();
    check("os_busy1_start", 64'(busy[1]), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("os_fin1_k%0d", k),  64'(clk_finish[1]), 64'(k == 3));
      check($sformatf("os_busy1_k%0d", k), 64'(busy[1]), 64'(k < 3));
    end
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    check("os_restart_busy", 64'(busy[1]), 1);
    check("os_restart_cnt",  64'(count[CNT_W +: CNT_W]), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("os2_fin1_k%0d", k), 64'(clk_finish[1]), 64'(k == 3));
    end
    check("os2_done_busy", 64'(busy[1]), 0);
    ch_en[1] = 1'b0;
    step();

    // ch2, M=4: start on the terminal tick suppresses the pulse
    max_count[2*CNT_W +: CNT_W] = 18'd4;
    ch_en[2] = 1'b1;
    step();
    step();
    step();
    step();
    check("st_cnt_term", 64'(count[2*CNT_W +: CNT_W]), 3);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    check("st_no_pulse", 64'(clk_finish[2]), 0);
    check("st_cnt_zero", 64'(count[2*CNT_W +: CNT_W]), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("st_fin2_k%0d", k), 64'(clk_finish[2]), 64'(k == 4));
      check($sformatf("st_any_k%0d", k),  64'(any_finish), 64'(k == 4));
    end

    // maxCount 5 -> 2 mid-count: current period stays 5, next is 2
    max_count[2*CNT_W +: CNT_W] = 18'd5;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    step();
    step();
    max_count[2*CNT_W +: CNT_W] = 18'd2;
    for (int k = 3; k <= 7; k++) begin
      step();
      check($sformatf("mc_fin2_k%0d", k), 64'(clk_finish[2]), 64'(k == 5 || k == 7));
      if (k == 4) check("mc_cnt2_k4", 64'(count[2*CNT_W +: CNT_W]), 4);
    end
    ch_en[2] = 1'b0;
    step();

    // PRESC=4, ch2 M=2, EN low for 10 clocks: pulse moves from clock 7 to 17
    max_count4[2*CNT_W +: CNT_W] = 18'd2;
    en4 = 1'b1;
    ch_en4[2] = 1'b1;
    step();
    for (int k = 1; k <= 20; k++) begin
      en4 = !(k >= 5 && k <= 14);
      step();
      check($sformatf("ps_fin_k%0d", k), 64'(clk_finish4[2]), 64'(k == 17));
      if (k == 10) begin
        check("ps_cnt_frozen",  64'(count4[2*CNT_W +: CNT_W]), 1);
        check("ps_busy_frozen", 64'(busy4[2]), 1);
      end
    end

    // Reset mid-count clears everything on the next edge
    ch_en[0] = 1'b1;
    step();
    step();
    step();
    check("mrst_cnt_before", 64'(count[0 +: CNT_W]), 2);
    rst_n = 1'b0;
    step();
    check("mrst_count",  64'(|count), 0);
    check("mrst_busy",   64'(busy), 0);
    check("mrst_finish", 64'(clk_finish), 0);
    check("mrst_busy4",  64'(busy4), 0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
